// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
// Mode/direction encodings match the raw sat/up input levels.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Limit a parallel-load value to the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
    if (value > max) begin
      clamp_load = max;
    end else begin
      clamp_load = value;
    end
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Divides enabled cycles by PRESCALE; step pulses on the last phase.
// PRESCALE=1 degenerates to a direct pass-through of en.
module count_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_s;
      assign unused_s = &{1'b0, clk, reset, restart};
      assign step     = en;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase_r;

      assign step = en && !restart && (phase_r == LAST);

      // Phase counter: restart wins, holds while disabled.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          phase_r <= '0;
        end else if (restart) begin
          phase_r <= '0;
        end else if (en) begin
          phase_r <= (phase_r == LAST) ? '0 : phase_r + PW'(1);
        end else begin
          phase_r <= phase_r;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down counter modulo MAX_COUNT+1 with prescale, load,
// wrap/saturate mode, terminal-count pulse and sticky overflow flag.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             ovf_r;
  logic             step_s;
  logic [WIDTH-1:0] q_step_s;
  logic             bnd_s;
  logic [WIDTH-1:0] load_q_s;

  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .restart(load),
    .step   (step_s)
  );

  assign load_q_s = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

  // Value after one step and whether that step hits the current boundary.
  always_comb begin
    q_step_s = q_r;
    bnd_s    = 1'b0;
    if (up == DIR_UP) begin
      if (q_r == MAX_Q) begin
        bnd_s    = 1'b1;
        q_step_s = (sat == MODE_WRAP) ? '0 : MAX_Q;
      end else begin
        q_step_s = q_r + WIDTH'(1);
      end
    end else begin
      if (q_r == '0) begin
        bnd_s    = 1'b1;
        q_step_s = (sat == MODE_SAT) ? '0 : MAX_Q;
      end else begin
        q_step_s = q_r - WIDTH'(1);
      end
    end
  end

  // Count, pulse and sticky flag registers; load beats a pending step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (load) begin
      q_r   <= load_q_s;
      tc_r  <= 1'b0;
      ovf_r <= ovf_r && !clr_ovf;
    end else if (step_s) begin
      q_r   <= q_step_s;
      tc_r  <= bnd_s;
      ovf_r <= bnd_s || (ovf_r && !clr_ovf);
    end else begin
      q_r   <= q_r;
      tc_r  <= 1'b0;
      ovf_r <= ovf_r && !clr_ovf;
    end
  end

  assign q   = q_r;
  assign tc  = tc_r;
  assign ovf = ovf_r;

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter: generalises the team's 8-bit T-flip-flop ripple counter to a single-clock design with configurable width, modulus and prescale, plus direction, parallel load, wrap/saturate mode, terminal-count pulse and sticky overflow. All state changes on one clock edge, so outputs are glitch-free and safe for downstream synchronous logic. Sits wherever the design needs event counting, timers or address sequencing.

## Interface

Parameters:
- WIDTH, 8, counter width in bits (≥2)
- MAX_COUNT, 2**WIDTH-1, highest count value (1 ≤ MAX_COUNT ≤ 2**WIDTH-1); count range 0..MAX_COUNT
- PRESCALE, 1, count step occurs once every PRESCALE enabled cycles (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable; low freezes counter and prescaler
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  mode: 0 = wrap, 1 = saturate at boundary
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value loaded when load=1
- clr_ovf  in  1  clears sticky ovf
- q  out  WIDTH  current count
- tc  out  1  one-cycle terminal-count pulse
- ovf  out  1  sticky boundary-hit flag

## Operation

- Priority per edge: reset > load > count step > hold.
- Reset (reset=0, asynchronous assert, synchronous-safe deassert by design context): q=0, tc=0, ovf=0, prescaler phase=0.
- Load: q <= min(load_val, MAX_COUNT); prescaler phase <= 0; tc <= 0; ovf unchanged. Load ignores en.
- Prescaler: when en=1 and no load, phase increments; step fires when phase == PRESCALE-1, phase then returns to 0. PRESCALE=1 → step every enabled cycle.
- Step, up=1: q<MAX_COUNT → q+1; q==MAX_COUNT → 0 (sat=0) or MAX_COUNT (sat=1).
- Step, up=0: q>0 → q-1; q==0 → MAX_COUNT (sat=0) or 0 (sat=1).
- Boundary event: step taken while q at boundary for current direction (MAX_COUNT up, 0 down), in either mode. On boundary event: tc=1 for exactly one cycle; ovf set.
- tc=0 on every cycle without a boundary event (repeated saturated steps give one pulse per step).
- ovf: cleared by clr_ovf; simultaneous set and clr_ovf → ovf stays 1 (set wins).
- Direction/mode changes take effect on the next step; no state reset.
- Arithmetic is modulo MAX_COUNT+1, never modulo 2**WIDTH unless MAX_COUNT=2**WIDTH-1.

## Timing

- All outputs registered; q, tc, ovf update on the same rising edge that samples the step condition (1-cycle latency from en/load to q).
- tc high in the cycle q first shows the wrapped/saturated value.
- Load and step never both take effect; load wins, prescaler restarts.
- Reset asserted mid-count: outputs go to reset values immediately (no clock needed); first step after release occurs PRESCALE enabled cycles later.
- en deasserted mid-prescale: phase held, resumes on re-enable.

## Structure

- Package counter_pkg: MODE_WRAP/MODE_SAT and DIR_UP/DIR_DOWN constants, a function clamp_load(value, max).
- One sub-module: count_prescaler (parameter PRESCALE; ports clk, reset, en, restart, step). Bypassed (step = en) when PRESCALE=1.
- Top holds count register, next-value mux, tc/ovf registers.

## Test plan

- Reset: drive reset=0 mid-count at q=37 → q=0, tc=0, ovf=0 without clock edge.
- Wrap up, WIDTH=4, MAX_COUNT=9: count from 0, en=1, up=1 → q 0..9, then 0 with tc=1 that cycle only, ovf=1.
- Saturate down, sat=1: load 2, up=0 → q 1, 0, 0, 0; tc pulses on each step at 0 (2 pulses over 2 steps), ovf=1.
- Load clamp and priority: MAX_COUNT=9, load=1 with load_val=15 and en=1 → q=9, tc=0; next step up → q=0, tc=1.
- Prescale: PRESCALE=3, en toggled 1,1,0,1 → q increments only after third enabled cycle; load during phase 2 restarts phase (next step 3 enabled cycles later).
- ovf clear race: clr_ovf=1 same cycle as boundary event → ovf=1; clr_ovf=1 next cycle with no event → ovf=0.
